// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding and widths.
package pll_sup_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_PLLRST    = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_STABLE    = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_FAIL      = 3'd4;

  // Largest of the three cycle parameters; sizes the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by a synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops before anyone looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL sequencer: pulses the PLL reset, qualifies lock for a programmed time,
// then releases core reset. Lock timeouts trigger bounded re-resets, then FAIL.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               core_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost
);

  localparam int TMR_W = $clog2(max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES)) + 1;

  localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   STABLE_LAST = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic               locked_s;
  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lost_nxt;
  logic               pll_rst_nxt, core_rst_nxt, ready_nxt, fail_nxt;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // State register plus registered outputs decoded from the next state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= ST_PLLRST;
      tmr       <= '0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      core_rst  <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      retry_cnt <= retry_nxt;
      lock_lost <= lost_nxt;
      pll_rst   <= pll_rst_nxt;
      core_rst  <= core_rst_nxt;
      ready     <= ready_nxt;
      fail      <= fail_nxt;
    end
  end

  // Next-state logic; the single timer is cleared whenever a state is entered.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    tmr_nxt   = tmr + 1'b1;
    retry_nxt = retry_cnt;
    lost_nxt  = 1'b0;
    unique case (state)
      ST_PLLRST: begin
        if (tmr == RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          tmr_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = ST_STABLE;
          tmr_nxt   = '0;
        end else if (tmr == TIMEOUT_LAST) begin
          tmr_nxt = '0;
          if (retry_cnt == RETRY_MAX) begin
            state_nxt = ST_FAIL;
          end else begin
            state_nxt = ST_PLLRST;
            retry_nxt = retry_cnt + 1'b1;
          end
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
          tmr_nxt   = '0;
        end else if (tmr == STABLE_LAST) begin
          state_nxt = ST_RUN;
          tmr_nxt   = '0;
          retry_nxt = '0;
        end
      end
      ST_RUN: begin
        tmr_nxt = '0;
        // Lock loss takes priority over a simultaneous relock request.
        if (!locked_s) begin
          state_nxt = ST_PLLRST;
          lost_nxt  = 1'b1;
        end else if (relock_req) begin
          state_nxt = ST_PLLRST;
        end
      end
      ST_FAIL: begin
        tmr_nxt = '0;
        if (relock_req) begin
          state_nxt = ST_PLLRST;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_PLLRST;
        tmr_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state, so outputs move on the same edge as the state.
  always_comb begin
    pll_rst_nxt  = (state_nxt == ST_PLLRST);
    core_rst_nxt = (state_nxt != ST_RUN);
    ready_nxt    = (state_nxt == ST_RUN);
    fail_nxt     = (state_nxt == ST_FAIL);
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus random
// lock/relock/reset traffic compared every cycle against a behavioural model.
module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int SC = 8;
  localparam int TO = 32;
  localparam int MR = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, core_rst, ready, fail, lock_lost;
  logic [3:0] retry_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_STABLE_CYCLES  (SC),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .core_rst   (core_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
  );

  // ---------------- behavioural reference model ----------------
  typedef enum {PH_PULSE, PH_WAIT, PH_QUAL, PH_RUN, PH_FAIL} phase_e;

  phase_e m_phase = PH_PULSE;
  int     m_el = 0;        // cycles already spent in the current phase
  int     m_retries = 0;
  bit     m_hist1 = 0, m_hist2 = 0;  // lock as seen 1 and 2 edges ago
  bit     m_lost = 0;

  task automatic model_step();
    bit seen;
    if (rst) begin
      m_phase = PH_PULSE; m_el = 0; m_retries = 0;
      m_hist1 = 0; m_hist2 = 0; m_lost = 0;
    end else begin
      seen    = m_hist2;
      m_hist2 = m_hist1;
      m_hist1 = pll_locked;
      m_lost  = 0;
      case (m_phase)
        PH_PULSE: if (m_el + 1 >= RP) begin m_phase = PH_WAIT; m_el = 0; end
                  else m_el++;
        PH_WAIT:  if (seen) begin m_phase = PH_QUAL; m_el = 0; end
                  else if (m_el + 1 >= TO) begin
                    m_el = 0;
                    if (m_retries >= MR) m_phase = PH_FAIL;
                    else begin m_retries++; m_phase = PH_PULSE; end
                  end else m_el++;
        PH_QUAL:  if (!seen) begin m_phase = PH_WAIT; m_el = 0; end
                  else if (m_el + 1 >= SC) begin m_phase = PH_RUN; m_retries = 0; m_el = 0; end
                  else m_el++;
        PH_RUN:   if (!seen) begin m_lost = 1; m_phase = PH_PULSE; m_el = 0; end
                  else if (relock_req) begin m_phase = PH_PULSE; m_el = 0; end
        PH_FAIL:  if (relock_req) begin m_phase = PH_PULSE; m_retries = 0; m_el = 0; end
        default:  m_phase = PH_PULSE;
      endcase
    end
  endtask

  function automatic logic [8:0] model_outs();
    return {m_phase == PH_PULSE, m_phase != PH_RUN, m_phase == PH_RUN,
            m_phase == PH_FAIL, 4'(m_retries), m_lost};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: DUT and model both take the edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge refclk);
    model_step();
    #1;
    check("outs", 32'({pll_rst, core_rst, ready, fail, retry_cnt, lock_lost}),
          32'(model_outs()));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // Ticks until ready; returns how many ticks that took (bounded).
  task automatic ticks_to_ready(output int n);
    n = 0;
    do begin tick(); n++; end while (!ready && n < 500);
  endtask

  task automatic wait_model_qual();
    int n = 0;
    while (m_phase != PH_QUAL && n < 500) begin tick(); n++; end
  endtask

  initial begin
    int n, pulses, lost_cnt;
    bit prev;

    // 1: power-up, reset values, pulse length, lock-to-ready latency
    rst = 1'b1; tick(); tick();
    check("reset_vals", 32'({pll_rst, core_rst, ready, fail, retry_cnt, lock_lost}), 32'h180);
    rst = 1'b0;
    n = 0;
    while (pll_rst && n < 100) begin tick(); n++; end
    check("pulse_len", n, RP);
    repeat (9) tick();
    pll_locked = 1'b1;
    ticks_to_ready(n);
    check("lock_to_ready", n, SC + 3);
    check("core_rst_released", core_rst, 0);

    // 4: lock loss in RUN
    pll_locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!lock_lost && n < 100);
    check("lost_delay", n, 3);
    check("lost_core_ready", 32'({core_rst, ready}), 32'b10);
    tick();
    check("lost_one_cycle", lock_lost, 0);
    pll_locked = 1'b1;
    ticks_to_ready(n);
    check("ready_back", ready, 1);

    // 2: lock never rises -> three pulses then FAIL
    pll_locked = 1'b0;
    do_reset();
    pulses = 1; prev = pll_rst; n = 0;
    while (!fail && n < 1000) begin
      tick(); n++;
      if (pll_rst && !prev) begin
        pulses++;
        check("retry_at_pulse", retry_cnt, pulses - 1);
      end
      prev = pll_rst;
    end
    check("fail_reached", fail, 1);
    check("pulse_count", pulses, MR + 1);
    check("fail_retry_cnt", retry_cnt, MR);
    repeat (5) tick();
    check("fail_hold", 32'({pll_rst, core_rst, fail}), 32'b011);

    // 5: relock in FAIL, relock in STABLE, relock coinciding with lock loss
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    check("fail_relock", 32'({fail, retry_cnt, pll_rst}), 32'b000001);
    pll_locked = 1'b1;
    wait_model_qual();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    check("relock_in_stable", pll_rst, 0);
    ticks_to_ready(n);
    check("ready_after_stable_relock", ready, 1);
    pll_locked = 1'b0;
    tick(); tick();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    lost_cnt = lock_lost ? 1 : 0;
    repeat (10) begin tick(); if (lock_lost) lost_cnt++; end
    check("lost_once", lost_cnt, 1);

    // 6: reset mid-STABLE
    pll_locked = 1'b1;
    wait_model_qual();
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_stable", 32'({pll_rst, core_rst, ready, fail, retry_cnt, lock_lost}), 32'h180);

    // 3: one-cycle glitch after 5 cycles in STABLE -> full requalification
    wait_model_qual();
    repeat (5) tick();
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    ticks_to_ready(n);
    check("glitch_requal", n, SC + 3);
    check("glitch_no_retry", retry_cnt, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 399) == 0);
      relock_req = ($urandom_range(0, 19) == 0);
      if (!pll_locked) pll_locked = ($urandom_range(0, 14) == 0);
      else             pll_locked = ($urandom_range(0, 59) != 0);
      tick();
    end
    rst = 1'b0; relock_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
